// File: rtl/mining_job_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : mining_job_controller_if
//  Desc     : Job, nonce-generator, core and result signals of the controller.
//  Revision : 1.0  initial release
// ============================================================================
interface mining_job_controller_if #(
  parameter int NUM_CORES = 3,
  parameter int IDX_W     = 4
);
  logic                 job_valid;
  logic                 job_ready;
  logic                 abort;
  logic [31:0]          nonce;
  logic                 nonce_overflow;
  logic                 nonce_restart;
  logic                 nonce_enable;
  logic                 core_start;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_hit;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_found;
  logic [31:0]          result_nonce;
  logic [IDX_W-1:0]     result_core_idx;
  logic [31:0]          batch_count;
  logic                 busy;

  // master = the controller; slave = job source, generator, cores and consumer
  modport master (
    input  job_valid, abort, nonce, nonce_overflow, core_done, core_hit, result_ready,
    output job_ready, nonce_restart, nonce_enable, core_start, result_valid,
           result_found, result_nonce, result_core_idx, batch_count, busy
  );

  modport slave (
    output job_valid, abort, nonce, nonce_overflow, core_done, core_hit, result_ready,
    input  job_ready, nonce_restart, nonce_enable, core_start, result_valid,
           result_found, result_nonce, result_core_idx, batch_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/mining_job_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mining_job_controller
//  Desc     : Runs one mining job in NUM_CORES-wide nonce batches and reports
//             the lowest-index winning nonce or exhaustion of the nonce space.
//  Revision : 1.0  initial release
// ============================================================================
module mining_job_controller #(
  parameter int NUM_CORES = 3,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  mining_job_controller_if.master bus
);

  localparam logic [31:0] c_NONCE_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] c_COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESTART = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    CHECK   = 3'd4,
    ADVANCE = 3'd5,
    REPORT  = 3'd6
  } state_t;

  state_t               r_state;
  logic [31:0]          r_base;
  logic [NUM_CORES-1:0] r_done_mask;
  logic [NUM_CORES-1:0] r_hit_mask;
  logic                 r_job_ready;
  logic                 r_nonce_restart;
  logic                 r_nonce_enable;
  logic                 r_core_start;
  logic                 r_result_valid;
  logic                 r_result_found;
  logic [31:0]          r_result_nonce;
  logic [IDX_W-1:0]     r_result_core_idx;
  logic [31:0]          r_batch_count;
  logic                 r_busy;

  logic [NUM_CORES-1:0] w_done_next;
  logic [NUM_CORES-1:0] w_hit_next;
  logic [NUM_CORES-1:0] w_valid_mask;
  logic [NUM_CORES-1:0] w_eff;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_exhausted;
  logic                 w_abortable;
  logic [31:0]          w_batch_inc;

  assign w_done_next = r_done_mask | bus.core_done;
  assign w_hit_next  = r_hit_mask | (bus.core_done & bus.core_hit);

  // A core whose nonce base+i wrapped past 32 bits cannot produce a real hit.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_valid_mask
    assign w_valid_mask[gi] = (r_base <= (c_NONCE_MAX - 32'(gi)));
  end

  assign w_eff       = r_hit_mask & w_valid_mask;
  assign w_exhausted = bus.nonce_overflow | (r_base > (c_NONCE_MAX - 32'(NUM_CORES)));
  assign w_abortable = (r_state != IDLE) && (r_state != REPORT);
  assign w_batch_inc = (r_batch_count == c_COUNT_MAX) ? r_batch_count : r_batch_count + 32'd1;

  always_comb begin
    w_winner = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_eff[i]) w_winner = IDX_W'(i);
    end
  end

  // Outputs are registered alongside the state so each reflects the state entered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state           <= IDLE;
      r_base            <= '0;
      r_done_mask       <= '0;
      r_hit_mask        <= '0;
      r_job_ready       <= 1'b1;
      r_nonce_restart   <= 1'b0;
      r_nonce_enable    <= 1'b0;
      r_core_start      <= 1'b0;
      r_result_valid    <= 1'b0;
      r_result_found    <= 1'b0;
      r_result_nonce    <= '0;
      r_result_core_idx <= '0;
      r_batch_count     <= '0;
      r_busy            <= 1'b0;
    end else begin
      r_nonce_restart <= 1'b0;
      r_nonce_enable  <= 1'b0;
      r_core_start    <= 1'b0;
      if (bus.abort && w_abortable) begin
        r_state     <= IDLE;
        r_job_ready <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_batch_count <= '0;
            if (bus.job_valid) begin
              r_state         <= RESTART;
              r_nonce_restart <= 1'b1;
              r_job_ready     <= 1'b0;
              r_busy          <= 1'b1;
            end
          end
          RESTART: begin
            r_state      <= START;
            r_core_start <= 1'b1;
          end
          START: begin
            r_base      <= bus.nonce;
            r_done_mask <= '0;
            r_hit_mask  <= '0;
            r_state     <= WAIT;
          end
          WAIT: begin
            r_done_mask <= w_done_next;
            r_hit_mask  <= w_hit_next;
            if (&w_done_next) r_state <= CHECK;
          end
          CHECK: begin
            r_batch_count <= w_batch_inc;
            if (|w_eff) begin
              r_state           <= REPORT;
              r_result_valid    <= 1'b1;
              r_result_found    <= 1'b1;
              r_result_nonce    <= r_base + 32'(w_winner);
              r_result_core_idx <= w_winner;
            end else if (w_exhausted) begin
              r_state           <= REPORT;
              r_result_valid    <= 1'b1;
              r_result_found    <= 1'b0;
              r_result_nonce    <= '0;
              r_result_core_idx <= '0;
            end else begin
              r_state        <= ADVANCE;
              r_nonce_enable <= 1'b1;
            end
          end
          ADVANCE: begin
            r_state      <= START;
            r_core_start <= 1'b1;
          end
          REPORT: begin
            if (bus.result_ready) begin
              r_state        <= IDLE;
              r_result_valid <= 1'b0;
              r_job_ready    <= 1'b1;
              r_busy         <= 1'b0;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.job_ready       = r_job_ready;
  assign bus.nonce_restart   = r_nonce_restart;
  assign bus.nonce_enable    = r_nonce_enable;
  assign bus.core_start      = r_core_start;
  assign bus.result_valid    = r_result_valid;
  assign bus.result_found    = r_result_found;
  assign bus.result_nonce    = r_result_nonce;
  assign bus.result_core_idx = r_result_core_idx;
  assign bus.batch_count     = r_batch_count;
  assign bus.busy            = r_busy;

endmodule
`default_nettype wire
